// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace checker.
// Trace entry layout: {pc, addr, wdata}.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  localparam int TRACE_W  = 69;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 31;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_MSB = 36;
  localparam int PC_LSB   = 37;
  localparam int PC_MSB   = 68;

endpackage

// File: rtl/wb_trace_checker_if.sv
// CPU debug writeback port bundle.
// The CPU drives it (master), the checker observes it (slave).
interface wb_trace_checker_if;
  logic [31:0] wb_pc;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;

  modport master (
    output wb_pc,
    output wb_wen,
    output wb_addr,
    output wb_wdata
  );

  modport slave (
    input wb_pc,
    input wb_wen,
    input wb_addr,
    input wb_wdata
  );
endinterface

// File: rtl/wb_trace_checker_timeout.sv
// Idle-cycle counter for the trace checker.
// expired is high once TIMEOUT-1 idle cycles have been counted.
module wb_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // next count: clear wins, saturate at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares CPU register writes against a golden trace.
// Sticky PASS/FAIL verdict with error capture.
module wb_trace_checker
  import wb_trace_pkg::*;
#(
  parameter int          TRACE_AW = 10,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] END_PC   = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  wb_trace_checker_if.slave   wb,
  output logic [TRACE_AW-1:0] trace_idx,
  input  logic [TRACE_W-1:0]  trace_rdata,
  output logic                running,
  output logic                pass,
  output logic                fail,
  output logic [1:0]          err_kind,
  output logic [TRACE_AW-1:0] err_idx,
  output logic [31:0]         err_pc,
  output logic [4:0]          err_addr,
  output logic [31:0]         err_wdata,
  output logic [TRACE_AW:0]   match_count
);

  state_e              state_q;
  logic [TRACE_AW-1:0] trace_idx_q;
  logic [TRACE_AW:0]   match_count_q;
  logic                pass_q;
  logic                fail_q;
  logic [1:0]          err_kind_q;
  logic [TRACE_AW-1:0] err_idx_q;
  logic [31:0]         err_pc_q;
  logic [4:0]          err_addr_q;
  logic [31:0]         err_wdata_q;

  logic [31:0] exp_pc;
  logic        at_end;
  logic        in_run;
  logic        launch;
  logic        wr_r0;
  logic        wr_reg;
  logic        hit;
  logic        idx_last;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        expired;

  assign exp_pc   = trace_rdata[PC_MSB:PC_LSB];
  assign at_end   = (exp_pc == END_PC);
  assign in_run   = (state_q == ST_RUN);
  assign launch   = start && !in_run;
  assign wr_r0    = wb.wb_wen && (wb.wb_addr == 5'd0);
  assign wr_reg   = wb.wb_wen && (wb.wb_addr != 5'd0);
  assign hit      = ({wb.wb_pc, wb.wb_addr, wb.wb_wdata} == trace_rdata);
  assign idx_last = &trace_idx_q;

  // any compared or r0 write restarts the idle window
  assign cnt_clr = launch || (in_run && !at_end && wb.wb_wen);
  assign cnt_inc = in_run && !at_end && !wb.wb_wen;

  wb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .inc    (cnt_inc),
    .expired(expired)
  );

  // checker FSM with registered verdict and error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      trace_idx_q   <= '0;
      match_count_q <= '0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      err_kind_q    <= ERR_NONE;
      err_idx_q     <= '0;
      err_pc_q      <= '0;
      err_addr_q    <= '0;
      err_wdata_q   <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (at_end) begin
            state_q <= ST_PASS;
            pass_q  <= 1'b1;
          end else if (wr_r0) begin
            state_q <= ST_RUN;
          end else if (wr_reg) begin
            if (hit) begin
              match_count_q <= match_count_q + (TRACE_AW+1)'(1);
              if (idx_last) begin
                state_q    <= ST_FAIL;
                fail_q     <= 1'b1;
                err_kind_q <= ERR_OVERFLOW;
                err_idx_q  <= trace_idx_q;
              end else begin
                trace_idx_q <= trace_idx_q + TRACE_AW'(1);
              end
            end else begin
              state_q     <= ST_FAIL;
              fail_q      <= 1'b1;
              err_kind_q  <= ERR_MISMATCH;
              err_idx_q   <= trace_idx_q;
              err_pc_q    <= wb.wb_pc;
              err_addr_q  <= wb.wb_addr;
              err_wdata_q <= wb.wb_wdata;
            end
          end else if (expired) begin
            state_q    <= ST_FAIL;
            fail_q     <= 1'b1;
            err_kind_q <= ERR_TIMEOUT;
            err_idx_q  <= trace_idx_q;
          end
        end
        default: begin
          if (start) begin
            state_q       <= ST_RUN;
            trace_idx_q   <= '0;
            match_count_q <= '0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            err_kind_q    <= ERR_NONE;
            err_idx_q     <= '0;
            err_pc_q      <= '0;
            err_addr_q    <= '0;
            err_wdata_q   <= '0;
          end
        end
      endcase
    end
  end

  assign running     = in_run;
  assign trace_idx   = trace_idx_q;
  assign match_count = match_count_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_kind    = err_kind_q;
  assign err_idx     = err_idx_q;
  assign err_pc      = err_pc_q;
  assign err_addr    = err_addr_q;
  assign err_wdata   = err_wdata_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Self-checking bench for wb_trace_checker.
// Golden trace in a small array, outcomes from an event-level model.
module tb_wb_trace_checker;

  localparam int          AW  = 2;
  localparam int          TO  = 16;
  localparam logic [31:0] END = 32'hFFFF_FFFF;

  typedef struct {
    bit        wen;
    bit [4:0]  addr;
    bit [31:0] pc;
    bit [31:0] wdata;
  } ev_t;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [AW-1:0] trace_idx;
  logic [68:0]   trace_rdata;
  logic          running, pass, fail;
  logic [1:0]    err_kind;
  logic [AW-1:0] err_idx;
  logic [31:0]   err_pc, err_wdata;
  logic [4:0]    err_addr;
  logic [AW:0]   match_count;

  logic [68:0] mem [0:3];
  ev_t         evq [$];

  int n_checks = 0;
  int n_fail   = 0;

  bit        e_pass, e_fail;
  bit [1:0]  e_kind;
  int        e_eidx, e_idx, e_mc, e_edges;
  bit [31:0] e_pc, e_wdata;
  bit [4:0]  e_addr;

  logic          pre_run;
  logic [AW-1:0] pre_idx;

  wb_trace_checker_if wbi ();

  assign trace_rdata = mem[trace_idx];

  wb_trace_checker #(
    .TRACE_AW(AW),
    .TIMEOUT (TO),
    .END_PC  (END)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wb         (wbi.slave),
    .trace_idx  (trace_idx),
    .trace_rdata(trace_rdata),
    .running    (running),
    .pass       (pass),
    .fail       (fail),
    .err_kind   (err_kind),
    .err_idx    (err_idx),
    .err_pc     (err_pc),
    .err_addr   (err_addr),
    .err_wdata  (err_wdata),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [68:0] ent(
    input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    return {pc, a, d};
  endfunction

  function automatic ev_t wr(input logic [68:0] x);
    ev_t e;
    e.wen = 1; e.pc = x[68:37]; e.addr = x[36:32]; e.wdata = x[31:0];
    return e;
  endfunction

  function automatic ev_t idle_ev();
    ev_t e;
    e.wen = 0; e.pc = 0; e.addr = 0; e.wdata = 0;
    return e;
  endfunction

  function automatic ev_t r0_ev();
    ev_t e;
    e.wen = 1; e.pc = 32'h100; e.addr = 0; e.wdata = 32'h1234;
    return e;
  endfunction

  // Walk the event list against the trace, one event per RUN edge.
  task automatic model();
    int  idx, idle;
    bit  done;
    ev_t e;
    idx = 0; idle = 0; done = 0;
    e_pass = 0; e_fail = 0; e_kind = 0; e_eidx = 0;
    e_pc = 0; e_addr = 0; e_wdata = 0; e_mc = 0; e_edges = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      e = (c < evq.size()) ? evq[c] : idle_ev();
      e_edges = c + 1;
      if (mem[idx][68:37] == END) begin
        e_pass = 1; done = 1;
      end else if (e.wen && e.addr == 0) begin
        idle = 0;
      end else if (e.wen) begin
        if ({e.pc, e.addr, e.wdata} == mem[idx]) begin
          e_mc++; idle = 0;
          if (idx == (1 << AW) - 1) begin
            e_fail = 1; e_kind = 3; e_eidx = idx; done = 1;
          end else begin
            idx++;
          end
        end else begin
          e_fail = 1; e_kind = 1; e_eidx = idx; done = 1;
          e_pc = e.pc; e_addr = e.addr; e_wdata = e.wdata;
        end
      end else begin
        if (idle == TO - 1) begin
          e_fail = 1; e_kind = 2; e_eidx = idx; done = 1;
        end else begin
          idle++;
        end
      end
    end
    if (!done) e_edges = 0;
    e_idx = idx;
  endtask

  task automatic drive(input ev_t e);
    wbi.wb_wen   = e.wen;
    wbi.wb_addr  = e.addr;
    wbi.wb_pc    = e.pc;
    wbi.wb_wdata = e.wdata;
  endtask

  // Pulse start, then play evq for a given number of RUN edges.
  task automatic run_dut(input int edges);
    @(negedge clk);
    start = 1;
    drive(idle_ev());
    @(negedge clk);
    start = 0;
    pre_run = 1;
    pre_idx = '0;
    for (int k = 0; k < edges; k++) begin
      drive((k < evq.size()) ? evq[k] : idle_ev());
      @(posedge clk);
      #1;
      if (k == edges - 2) begin
        pre_run = running;
        pre_idx = trace_idx;
      end
      if (k < edges - 1) @(negedge clk);
    end
    drive(idle_ev());
  endtask

  task automatic load_basic();
    mem[0] = ent(32'h0, 5'd1, 32'h5);
    mem[1] = ent(32'h4, 5'd2, 32'hA);
    mem[2] = ent(32'h8, 5'd3, 32'hF);
    mem[3] = {END, 37'd0};
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({running, pass, fail, err_kind, err_idx, err_pc, err_addr,
         err_wdata, match_count, trace_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset: run=%b pass=%b fail=%b kind=%0d idx=%0d mc=%0d required all zero",
               running, pass, fail, err_kind, trace_idx, match_count);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_pass();
    load_basic();
    evq = {wr(mem[0]), wr(mem[1]), wr(mem[2])};
    model();
    run_dut(e_edges);
    n_checks++;
    if (e_edges !== 4 || pre_idx !== 2'd3 || pre_run !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_timing: edges=%0d pre_idx=%0d pre_run=%b required 4 3 1",
               e_edges, pre_idx, pre_run);
    end
    n_checks++;
    if ({pass, fail, err_kind, match_count} !== {1'b1, 1'b0, 2'd0, 3'd3}) begin
      n_fail++;
      $display("FAIL pass_verdict: pass=%b fail=%b kind=%0d mc=%0d required 1 0 0 3",
               pass, fail, err_kind, match_count);
    end
  endtask

  task automatic test_mismatch();
    ev_t b;
    load_basic();
    b = wr(mem[1]);
    b.wdata = 32'h6;
    evq = {wr(mem[0]), b, wr(mem[2])};
    model();
    run_dut(e_edges);
    n_checks++;
    if ({fail, pass, err_kind, err_idx, match_count} !==
        {1'b1, 1'b0, 2'd1, 2'd1, 3'd1}) begin
      n_fail++;
      $display("FAIL mismatch_verdict: fail=%b pass=%b kind=%0d eidx=%0d mc=%0d required 1 0 1 1 1",
               fail, pass, err_kind, err_idx, match_count);
    end
    n_checks++;
    if ({err_pc, err_addr, err_wdata} !== {32'h4, 5'd2, 32'h6}) begin
      n_fail++;
      $display("FAIL mismatch_capture: pc=%h addr=%0d wdata=%h required 4 2 6",
               err_pc, err_addr, err_wdata);
    end
  endtask

  task automatic test_r0();
    load_basic();
    evq = {r0_ev(), wr(mem[0]), r0_ev(), r0_ev(), wr(mem[1]),
           r0_ev(), wr(mem[2]), r0_ev()};
    model();
    run_dut(e_edges);
    n_checks++;
    if ({pass, fail, match_count, trace_idx} !== {1'b1, 1'b0, 3'd3, 2'd3}) begin
      n_fail++;
      $display("FAIL r0_ignored: pass=%b fail=%b mc=%0d idx=%0d required 1 0 3 3",
               pass, fail, match_count, trace_idx);
    end
    n_checks++;
    if (pre_run !== 1'b1 || e_edges !== 8) begin
      n_fail++;
      $display("FAIL r0_timing: pre_run=%b edges=%0d required 1 8", pre_run, e_edges);
    end
  endtask

  task automatic test_timeout();
    load_basic();
    evq = {};
    run_dut(TO);
    n_checks++;
    if (pre_run !== 1'b1 || {fail, err_kind, err_idx} !== {1'b1, 2'd2, 2'd0}) begin
      n_fail++;
      $display("FAIL timeout_16: pre_run=%b fail=%b kind=%0d eidx=%0d required 1 1 2 0",
               pre_run, fail, err_kind, err_idx);
    end
    evq = {};
    for (int i = 0; i < TO - 2; i++) evq.push_back(idle_ev());
    evq.push_back(r0_ev());
    run_dut(TO);
    n_checks++;
    if (fail !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_kick: fail=%b running=%b required 0 1", fail, running);
    end
    repeat (TO - 1) @(posedge clk);
    #1;
    n_checks++;
    if ({fail, err_kind} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL timeout_after_kick: fail=%b kind=%0d required 1 2", fail, err_kind);
    end
  endtask

  task automatic test_reset_mid_run();
    load_basic();
    evq = {wr(mem[0]), wr(mem[1])};
    run_dut(2);
    n_checks++;
    if (trace_idx !== 2'd2 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: idx=%0d running=%b required 2 1", trace_idx, running);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({running, pass, fail, err_kind, match_count, trace_idx} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: run=%b pass=%b fail=%b mc=%0d idx=%0d required all zero",
               running, pass, fail, match_count, trace_idx);
    end
    @(negedge clk);
    rst = 0;
    evq = {wr(mem[0]), wr(mem[1]), wr(mem[2])};
    run_dut(4);
    n_checks++;
    if ({pass, fail, match_count} !== {1'b1, 1'b0, 3'd3}) begin
      n_fail++;
      $display("FAIL midrun_rerun: pass=%b fail=%b mc=%0d required 1 0 3",
               pass, fail, match_count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++)
      mem[i] = ent(32'h40 + 32'(4 * i), 5'(i + 7), $urandom);
    evq = {wr(mem[0]), wr(mem[1]), wr(mem[2]), wr(mem[3])};
    run_dut(4);
    n_checks++;
    if ({fail, pass, err_kind, err_idx, trace_idx} !==
        {1'b1, 1'b0, 2'd3, 2'd3, 2'd3}) begin
      n_fail++;
      $display("FAIL overflow: fail=%b pass=%b kind=%0d eidx=%0d idx=%0d required 1 0 3 3 3",
               fail, pass, err_kind, err_idx, trace_idx);
    end
  endtask

  task automatic test_random();
    int        send;
    logic [68:0] x;
    for (int it = 0; it < 40; it++) begin
      send = $urandom_range(4, 1);
      for (int i = 0; i < 4; i++) begin
        mem[i] = ent($urandom & 32'hFFFF_FFFC, 5'($urandom_range(31, 1)), $urandom);
        if (i == send && send < 4) mem[i] = {END, 37'($urandom)};
      end
      evq = {};
      for (int i = 0; i < send; i++) begin
        int gap;
        gap = ($urandom_range(9, 0) == 0) ? $urandom_range(20, 12)
                                          : $urandom_range(3, 0);
        for (int g = 0; g < gap; g++)
          evq.push_back($urandom_range(1, 0) ? r0_ev() : idle_ev());
        x = mem[i];
        if ($urandom_range(7, 0) == 0) x[$urandom_range(68, 0)] ^= 1'b1;
        evq.push_back(wr(x));
      end
      model();
      n_checks++;
      if (e_edges == 0) begin
        n_fail++;
        $display("FAIL rand_model_budget: iter=%0d no verdict within bound", it);
        continue;
      end
      run_dut(e_edges);
      n_checks++;
      if (pre_run !== 1'b1 || {pass, fail, err_kind} !== {e_pass, e_fail, e_kind}) begin
        n_fail++;
        $display("FAIL rand_verdict[%0d]: pre_run=%b pass=%b fail=%b kind=%0d required 1 %b %b %0d",
                 it, pre_run, pass, fail, err_kind, e_pass, e_fail, e_kind);
      end
      n_checks++;
      if (err_idx !== AW'(e_eidx) || trace_idx !== AW'(e_idx) ||
          match_count !== (AW+1)'(e_mc)) begin
        n_fail++;
        $display("FAIL rand_index[%0d]: eidx=%0d idx=%0d mc=%0d required %0d %0d %0d",
                 it, err_idx, trace_idx, match_count, e_eidx, e_idx, e_mc);
      end
      n_checks++;
      if ({err_pc, err_addr, err_wdata} !== {e_pc, e_addr, e_wdata}) begin
        n_fail++;
        $display("FAIL rand_capture[%0d]: pc=%h addr=%0d wdata=%h required %h %0d %h",
                 it, err_pc, err_addr, err_wdata, e_pc, e_addr, e_wdata);
      end
    end
  endtask

  initial begin
    drive(idle_ev());
    load_basic();
    test_reset();
    test_pass();
    test_mismatch();
    test_r0();
    test_timeout();
    test_reset_mid_run();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
